// File: rtl/gate_drive_guard_if.sv
// Request/drive bundle between the discharge controller and the gate-drive guard.
interface gate_drive_guard_if;
   logic [1:0] req_buck1;
   logic [1:0] req_buck2;
   logic [1:0] req_res1;
   logic [1:0] req_res2;
   logic       req_deion;
   logic       ext_fault;
   logic       fault_clr;
   logic [1:0] gate_buck1;
   logic [1:0] gate_buck2;
   logic [1:0] gate_res1;
   logic [1:0] gate_res2;
   logic       gate_deion;
   logic       fault;
   logic [2:0] fault_cause;
   logic [3:0] fault_leg;
   logic [3:0] dead_stall;

   modport master (
      output req_buck1, req_buck2, req_res1, req_res2, req_deion, ext_fault, fault_clr,
      input  gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion,
      input  fault, fault_cause, fault_leg, dead_stall
   );

   modport slave (
      input  req_buck1, req_buck2, req_res1, req_res2, req_deion, ext_fault, fault_clr,
      output gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion,
      output fault, fault_cause, fault_leg, dead_stall
   );
endinterface

// File: rtl/gate_drive_guard.sv
// Shoot-through / dead-time guard for four half-bridge legs plus the de-ion switch, with fault latch.
// Optional per-leg high-side on-time watchdog is enabled by defining GATE_ON_WATCHDOG_EN.
module gate_drive_guard #(
   parameter int unsigned      CNT_W       = 16,
   parameter logic [CNT_W-1:0] DEAD_TIME   = 16'd10,
   parameter logic [31:0]      MAX_ON_TIME = 32'd10000
) (
   input logic               clk,
   input logic               rst_n,
   gate_drive_guard_if.slave bus
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_UP    = 2'b01,
      ST_DN    = 2'b10,
      ST_FAULT = 2'b11
   } leg_state_e;

   typedef enum logic [1:0] {
      LAST_NONE = 2'b00,
      LAST_UP   = 2'b01,
      LAST_DN   = 2'b10
   } last_on_e;

   localparam logic [1:0]       REQ_OFF = 2'b00;
   localparam logic [1:0]       REQ_UP  = 2'b10;
   localparam logic [1:0]       REQ_DN  = 2'b01;
   localparam logic [1:0]       REQ_BAD = 2'b11;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       req_s [4];
   leg_state_e       state_r [4];
   leg_state_e       state_next_s [4];
   logic [CNT_W-1:0] off_cnt_r [4];
   logic [CNT_W-1:0] off_cnt_next_s [4];
   last_on_e         last_on_r [4];
   last_on_e         last_on_next_s [4];
   logic [1:0]       gate_r [4];
   logic [1:0]       gate_next_s [4];
   logic [3:0]       stall_r;
   logic [3:0]       stall_next_s;
   logic [3:0]       illegal_s;
   logic [3:0]       wd_hit_s;
   logic [3:0]       fault_leg_r;
   logic [3:0]       fault_leg_next_s;
   logic [2:0]       fault_cause_r;
   logic [2:0]       fault_cause_next_s;
   logic             fault_r;
   logic             fault_next_s;
   logic             set_any_s;
   logic             clr_ok_s;
   logic             req_idle_s;
   logic             deion_r;
   logic             deion_next_s;

   // Gather leg requests into an indexable array, order {res2,res1,buck2,buck1}
   always_comb begin
      req_s[0] = bus.req_buck1;
      req_s[1] = bus.req_buck2;
      req_s[2] = bus.req_res1;
      req_s[3] = bus.req_res2;
   end

`ifdef GATE_ON_WATCHDOG_EN
   logic [31:0] wd_cnt_r [4];

   // Watchdog trips once a leg has spent MAX_ON_TIME consecutive cycles in UP
   always_comb begin
      wd_hit_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         wd_hit_s[i] = (state_r[i] == ST_UP) && (wd_cnt_r[i] >= MAX_ON_TIME);
      end
   end

   // Consecutive on-time counters, cleared whenever the leg leaves UP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wd_cnt_r[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            wd_cnt_r[i] <= (state_next_s[i] == ST_UP) ? (wd_cnt_r[i] + 32'd1) : 32'd0;
         end
      end
   end
`else
   logic unused_max_on_s;

   assign wd_hit_s        = 4'b0000;
   assign unused_max_on_s = ^MAX_ON_TIME;
`endif

   // Fault latch: set beats clear; a clear needs every request idle and no trip present
   always_comb begin
      illegal_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         illegal_s[i] = (req_s[i] == REQ_BAD);
      end
      req_idle_s   = (req_s[0] == REQ_OFF) && (req_s[1] == REQ_OFF) &&
                     (req_s[2] == REQ_OFF) && (req_s[3] == REQ_OFF) && !bus.req_deion;
      set_any_s    = (|illegal_s) || bus.ext_fault || (|wd_hit_s);
      clr_ok_s     = fault_r && bus.fault_clr && !bus.ext_fault && req_idle_s;
      fault_next_s = set_any_s || (fault_r && !clr_ok_s);
      if (set_any_s) begin
         fault_cause_next_s = fault_cause_r | {(|wd_hit_s), bus.ext_fault, (|illegal_s)};
         fault_leg_next_s   = fault_leg_r | illegal_s | wd_hit_s;
      end else if (clr_ok_s) begin
         fault_cause_next_s = 3'b000;
         fault_leg_next_s   = 4'b0000;
      end else begin
         fault_cause_next_s = fault_cause_r;
         fault_leg_next_s   = fault_leg_r;
      end
   end

   // Per-leg next state: dead-time gating in OFF, same-switch re-enable allowed via last_on
   always_comb begin
      stall_next_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         state_next_s[i]   = state_r[i];
         off_cnt_next_s[i] = off_cnt_r[i];
         last_on_next_s[i] = last_on_r[i];
         gate_next_s[i]    = REQ_OFF;
         if (fault_next_s) begin
            state_next_s[i]   = ST_FAULT;
            off_cnt_next_s[i] = {CNT_W{1'b0}};
            last_on_next_s[i] = LAST_NONE;
         end else begin
            case (state_r[i])
               ST_OFF: begin
                  off_cnt_next_s[i] = (off_cnt_r[i] >= DEAD_TIME) ? off_cnt_r[i]
                                                                  : (off_cnt_r[i] + CNT_ONE);
                  if ((req_s[i] == REQ_UP) &&
                      ((off_cnt_r[i] >= DEAD_TIME) || (last_on_r[i] == LAST_UP))) begin
                     state_next_s[i] = ST_UP;
                     gate_next_s[i]  = REQ_UP;
                  end else if ((req_s[i] == REQ_DN) &&
                               ((off_cnt_r[i] >= DEAD_TIME) || (last_on_r[i] == LAST_DN))) begin
                     state_next_s[i] = ST_DN;
                     gate_next_s[i]  = REQ_DN;
                  end else if (req_s[i] != REQ_OFF) begin
                     stall_next_s[i] = 1'b1;
                  end else begin
                     stall_next_s[i] = 1'b0;
                  end
               end
               ST_UP: begin
                  if (req_s[i] == REQ_UP) begin
                     gate_next_s[i] = REQ_UP;
                  end else begin
                     state_next_s[i]   = ST_OFF;
                     off_cnt_next_s[i] = {CNT_W{1'b0}};
                     last_on_next_s[i] = LAST_UP;
                  end
               end
               ST_DN: begin
                  if (req_s[i] == REQ_DN) begin
                     gate_next_s[i] = REQ_DN;
                  end else begin
                     state_next_s[i]   = ST_OFF;
                     off_cnt_next_s[i] = {CNT_W{1'b0}};
                     last_on_next_s[i] = LAST_DN;
                  end
               end
               ST_FAULT: begin
                  state_next_s[i]   = ST_OFF;
                  off_cnt_next_s[i] = {CNT_W{1'b0}};
                  last_on_next_s[i] = LAST_NONE;
               end
               default: begin
                  state_next_s[i]   = ST_OFF;
                  off_cnt_next_s[i] = {CNT_W{1'b0}};
                  last_on_next_s[i] = LAST_NONE;
               end
            endcase
         end
      end
      deion_next_s = bus.req_deion && !fault_next_s &&
                     (gate_next_s[0] == REQ_OFF) && (gate_next_s[1] == REQ_OFF);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            state_r[i]   <= ST_OFF;
            off_cnt_r[i] <= {CNT_W{1'b0}};
            last_on_r[i] <= LAST_NONE;
            gate_r[i]    <= 2'b00;
         end
         stall_r       <= 4'b0000;
         deion_r       <= 1'b0;
         fault_r       <= 1'b0;
         fault_cause_r <= 3'b000;
         fault_leg_r   <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_r[i]   <= state_next_s[i];
            off_cnt_r[i] <= off_cnt_next_s[i];
            last_on_r[i] <= last_on_next_s[i];
            gate_r[i]    <= gate_next_s[i];
         end
         stall_r       <= stall_next_s;
         deion_r       <= deion_next_s;
         fault_r       <= fault_next_s;
         fault_cause_r <= fault_cause_next_s;
         fault_leg_r   <= fault_leg_next_s;
      end
   end

   assign bus.gate_buck1  = gate_r[0];
   assign bus.gate_buck2  = gate_r[1];
   assign bus.gate_res1   = gate_r[2];
   assign bus.gate_res2   = gate_r[3];
   assign bus.gate_deion  = deion_r;
   assign bus.fault       = fault_r;
   assign bus.fault_cause = fault_cause_r;
   assign bus.fault_leg   = fault_leg_r;
   assign bus.dead_stall  = stall_r;

endmodule
